// File: rtl/pipeline_stage_reg.sv
// Parametrised valid/ready pipeline stage with a one-entry skid buffer, flush and bubble gating.
// Optional performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipeline_stage_reg #(
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned DATA_W = 69
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       beat_cnt
`endif
);

    logic              main_valid_q;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [DATA_W-1:0] main_data_q;
    logic              skid_valid_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;
    logic              in_fire;
    logic              out_fire;

    // No path from out_ready: the skid entry absorbs the beat accepted under backpressure.
    assign in_ready  = ~skid_valid_q & ~flush & ~rst;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = main_valid_q & out_ready;

    assign out_valid = main_valid_q;
    assign out_ctrl  = main_ctrl_q & {CTRL_W{main_valid_q}};
    assign out_data  = main_data_q & {DATA_W{main_valid_q}};

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= '0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
        end else if (!main_valid_q) begin
            if (in_fire) begin
                main_valid_q <= 1'b1;
                main_ctrl_q  <= in_ctrl;
                main_data_q  <= in_data;
            end
        end else if (!skid_valid_q) begin
            if (in_fire && out_fire) begin
                main_ctrl_q <= in_ctrl;
                main_data_q <= in_data;
            end else if (in_fire) begin
                skid_valid_q <= 1'b1;
                skid_ctrl_q  <= in_ctrl;
                skid_data_q  <= in_data;
            end else if (out_fire) begin
                main_valid_q <= 1'b0;
            end
        end else if (out_fire) begin
            main_ctrl_q  <= skid_ctrl_q;
            main_data_q  <= skid_data_q;
            skid_valid_q <= 1'b0;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    // Counters survive flush so bubble insertion does not hide stall history.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            beat_cnt  <= '0;
        end else begin
            if (main_valid_q && !out_ready && stall_cnt != 32'hFFFF_FFFF) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (out_fire && beat_cnt != 32'hFFFF_FFFF) begin
                beat_cnt <= beat_cnt + 32'd1;
            end
        end
    end
`else
    // Performance counters not built.
`endif

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Self-checking bench for pipeline_stage_reg: directed scenarios then random traffic,
// compared against a queue-based model of the stage contents.
module tb_pipeline_stage_reg;

    localparam int unsigned CW = 4;
    localparam int unsigned DW = 69;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]   stall_cnt;
    logic [31:0]   beat_cnt;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    beat_t       q[$];
    int unsigned stall_m = 0;
    int unsigned beat_m = 0;

    always #5 clk = ~clk;

    pipeline_stage_reg #(
        .CTRL_W(CW),
        .DATA_W(DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_data (out_data)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .beat_cnt (beat_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs after the falling edge, check outputs against the model,
    // then let the rising edge advance both DUT and model.
    task automatic cycle(input logic r, input logic f, input logic iv,
                         input logic [CW-1:0] ic, input logic [DW-1:0] id, input logic ordy);
        beat_t         b;
        logic          exp_v;
        logic          exp_rdy;
        logic [CW-1:0] exp_c;
        logic [DW-1:0] exp_d;
        logic          ifire;
        logic          ofire;
        @(negedge clk);
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_ctrl   = ic;
        in_data   = id;
        out_ready = ordy;
        #1;
        exp_v   = (q.size() > 0);
        exp_rdy = (q.size() < 2) && !f && !r;
        exp_c   = exp_v ? q[0].c : '0;
        exp_d   = exp_v ? q[0].d : '0;
        chk("out_valid", 96'(out_valid), 96'(exp_v));
        chk("in_ready", 96'(in_ready), 96'(exp_rdy));
        chk("out_ctrl", 96'(out_ctrl), 96'(exp_c));
        chk("out_data", 96'(out_data), 96'(exp_d));
`ifdef PIPE_STAGE_PERF_EN
        chk("stall_cnt", 96'(stall_cnt), 96'(stall_m));
        chk("beat_cnt", 96'(beat_cnt), 96'(beat_m));
`endif
        ifire = iv && exp_rdy;
        ofire = exp_v && ordy;
        @(posedge clk);
        if (r) begin
            stall_m = 0;
            beat_m  = 0;
        end else begin
            if (exp_v && !ordy && stall_m != 32'hFFFF_FFFF) stall_m++;
            if (ofire && beat_m != 32'hFFFF_FFFF) beat_m++;
        end
        if (r || f) begin
            q.delete();
        end else begin
            if (ofire) void'(q.pop_front());
            if (ifire) begin
                b.c = ic;
                b.d = id;
                q.push_back(b);
            end
        end
    endtask

    initial begin
        logic [95:0] r96;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Streaming 1..4 at full rate.
        for (int i = 1; i <= 4; i++) cycle(0, 0, 1, CW'(i), DW'(i), 1);
        repeat (2) cycle(0, 0, 0, '0, '0, 1);

        // Backpressure into the skid entry, then drain in order.
        cycle(0, 0, 1, 4'h1, DW'('hA), 1);
        cycle(0, 0, 1, 4'h2, DW'('hB), 0);
        cycle(0, 0, 1, 4'h3, DW'('hC), 0);
        cycle(0, 0, 1, 4'h3, DW'('hC), 0);
        cycle(0, 0, 1, 4'h3, DW'('hC), 1);
        cycle(0, 0, 1, 4'h3, DW'('hC), 1);
        repeat (2) cycle(0, 0, 0, '0, '0, 1);

        // Flush while both entries are held; offered beat during flush is refused.
        cycle(0, 0, 1, 4'hF, DW'('h11), 0);
        cycle(0, 0, 1, 4'hF, DW'('h22), 0);
        cycle(0, 1, 1, 4'hF, DW'('h99), 0);
        cycle(0, 0, 1, 4'h5, DW'('h33), 1);
        repeat (2) cycle(0, 0, 0, '0, '0, 1);

        // Bubbles with control lines driven high.
        repeat (3) cycle(0, 0, 0, 4'hF, '1, 1);

        // Three beats with five stall cycles, flush keeps counts, then reset mid-skid.
        cycle(0, 0, 1, 4'h1, DW'('h1), 0);
        repeat (5) cycle(0, 0, 0, '0, '0, 0);
        cycle(0, 0, 1, 4'h2, DW'('h2), 1);
        cycle(0, 0, 1, 4'h3, DW'('h3), 1);
        repeat (2) cycle(0, 0, 0, '0, '0, 1);
        cycle(0, 1, 0, '0, '0, 1);
        cycle(0, 0, 1, 4'h7, DW'('h44), 0);
        cycle(0, 0, 1, 4'h7, DW'('h55), 0);
        cycle(1, 0, 1, 4'h7, DW'('h66), 0);
        cycle(1, 1, 1, 4'h7, DW'('h66), 1);
        cycle(0, 0, 1, 4'h6, DW'('h77), 1);
        repeat (2) cycle(0, 0, 0, '0, '0, 1);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            r96 = {$urandom, $urandom, $urandom};
            cycle($urandom_range(99) < 2, $urandom_range(99) < 4, $urandom_range(99) < 70,
                  CW'($urandom), r96[DW-1:0], $urandom_range(99) < 60);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
